// File: rtl/soc_run_supervisor.sv
// Host-side run supervisor for the SoC start/finish handshake: holds the CPU in reset,
// pulses start, waits for the finish rise, counts cycles and reports sticky run status.
module soc_run_supervisor #(
    parameter int RST_CYCLES = 3,
    parameter int MAX_CYCLES = 10000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             go,
    input  logic             abort,
    input  logic             cpu_finish,
    output logic             cpu_rst_b,
    output logic             cpu_start,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic             aborted,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTQ,
        S_SETTLE,
        S_PULSE,
        S_WAITLO,
        S_WAITHI,
        S_DONE
    } state_t;

    localparam int              PH_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

    state_t            state;
    logic [PH_W-1:0]   phase;
    logic [CNT_W-1:0]  cycles_inc;

    assign cycles_inc = cycles + CNT_W'(1);

    // NOTE: every register, including outputs, lives in this one block and uses <= only,
    // so each branch sees the pre-edge values and the reset is purely synchronous.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= S_IDLE;
            phase     <= '0;
            cpu_rst_b <= 1'b0;
            cpu_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            aborted   <= 1'b0;
            cycles    <= '0;
        end else if (abort && state != S_IDLE) begin
            // Abort overrides everything; cycles freezes and only the aborted flag remains.
            state     <= S_IDLE;
            busy      <= 1'b0;
            cpu_start <= 1'b0;
            cpu_rst_b <= 1'b0;
            aborted   <= 1'b1;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_RSTQ;
                        busy      <= 1'b1;
                        cycles    <= '0;
                        done      <= 1'b0;
                        timed_out <= 1'b0;
                        aborted   <= 1'b0;
                        cpu_rst_b <= 1'b0;
                        phase     <= PH_LOAD;
                    end
                end
                S_RSTQ: begin
                    if (phase == '0) begin
                        state     <= S_SETTLE;
                        cpu_rst_b <= 1'b1;
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                S_SETTLE: begin
                    state     <= S_PULSE;
                    cpu_start <= 1'b1;
                end
                S_PULSE: begin
                    state     <= S_WAITLO;
                    cpu_start <= 1'b0;
                end
                S_WAITLO: begin
                    cycles <= cycles_inc;
                    if (cycles_inc == CNT_MAX) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        timed_out <= 1'b1;
                        cpu_rst_b <= 1'b0;
                    end else if (!cpu_finish) begin
                        state <= S_WAITHI;
                    end
                end
                S_WAITHI: begin
                    // A finish rise on the boundary cycle beats the timeout.
                    if (cpu_finish) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        cycles <= cycles_inc;
                        if (cycles_inc == CNT_MAX) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            timed_out <= 1'b1;
                            cpu_rst_b <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_run_supervisor.sv
// Scoreboard bench for soc_run_supervisor: expected run results are queued when a run is
// launched and compared when the supervisor drops busy.
module tb_soc_run_supervisor;

    localparam int RST_CYCLES = 3;
    localparam int MAX_CYCLES = 50;
    localparam int CNT_W      = 16;

    typedef struct {
        logic             done;
        logic             timed_out;
        logic             aborted;
        logic [CNT_W-1:0] cycles;
        logic             cpu_rst_b;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             go = 1'b0;
    logic             abort = 1'b0;
    logic             cpu_finish = 1'b0;
    logic             cpu_rst_b;
    logic             cpu_start;
    logic             busy;
    logic             done;
    logic             timed_out;
    logic             aborted;
    logic [CNT_W-1:0] cycles;

    int      n_checks = 0;
    int      n_fail   = 0;
    result_t exp_q[$];

    soc_run_supervisor #(
        .RST_CYCLES(RST_CYCLES),
        .MAX_CYCLES(MAX_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .go        (go),
        .abort     (abort),
        .cpu_finish(cpu_finish),
        .cpu_rst_b (cpu_rst_b),
        .cpu_start (cpu_start),
        .busy      (busy),
        .done      (done),
        .timed_out (timed_out),
        .aborted   (aborted),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_exp(input logic d, input logic t, input logic a,
                            input int cyc, input logic rb);
        result_t r;
        r.done      = d;
        r.timed_out = t;
        r.aborted   = a;
        r.cycles    = CNT_W'(cyc);
        r.cpu_rst_b = rb;
        exp_q.push_back(r);
    endtask

    task automatic compare_result(input string tag);
        result_t r;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            r = exp_q.pop_front();
            check({tag, "_busy"},      32'(busy),      32'd0);
            check({tag, "_done"},      32'(done),      32'(r.done));
            check({tag, "_timed_out"}, 32'(timed_out), 32'(r.timed_out));
            check({tag, "_aborted"},   32'(aborted),   32'(r.aborted));
            check({tag, "_cycles"},    32'(cycles),    32'(r.cycles));
            check({tag, "_cpu_rst_b"}, 32'(cpu_rst_b), 32'(r.cpu_rst_b));
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({tag, "_idle_reached"}, 32'(busy), 32'd0);
    endtask

    // Launch a run and check the reset/settle/start timing; returns in WAITLO.
    task automatic launch(input string tag, input logic with_abort);
        go    = 1'b1;
        abort = with_abort;
        step();
        go    = 1'b0;
        abort = 1'b0;
        check({tag, "_go_busy"},  32'(busy), 32'd1);
        check({tag, "_go_flags"}, 32'({done, timed_out, aborted}), 32'd0);
        check({tag, "_go_cycles"}, 32'(cycles), 32'd0);
        for (int i = 0; i < RST_CYCLES; i++) begin
            check({tag, "_rstq_low"}, 32'({cpu_rst_b, cpu_start}), 32'd0);
            if (i < RST_CYCLES - 1) step();
        end
        step();
        check({tag, "_settle"}, 32'({cpu_rst_b, cpu_start}), 32'b10);
        step();
        check({tag, "_pulse"}, 32'({cpu_rst_b, cpu_start}), 32'b11);
        step();
        check({tag, "_waitlo"}, 32'({busy, cpu_rst_b, cpu_start}), 32'b110);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle behaviour
        steps(3);
        check("reset_outs", 32'({cpu_rst_b, cpu_start, busy, done, timed_out, aborted}), 32'd0);
        check("reset_cycles", 32'(cycles), 32'd0);
        rst_b = 1'b1;
        steps(3);
        check("idle_outs", 32'({cpu_rst_b, cpu_start, busy, done, timed_out, aborted}), 32'd0);
        check("idle_cycles", 32'(cycles), 32'd0);

        // Normal run: finish high for 2 wait cycles, low for 18, then rises
        launch("normal", 1'b0);
        push_exp(1'b1, 1'b0, 1'b0, 2 + 18, 1'b1);
        cpu_finish = 1'b1;
        steps(2);
        cpu_finish = 1'b0;
        steps(18);
        check("normal_pre_busy", 32'(busy), 32'd1);
        cpu_finish = 1'b1;
        wait_idle("normal", 10);
        compare_result("normal");

        // Timeout with finish stuck high; launched with go and abort together
        launch("timeout", 1'b1);
        push_exp(1'b0, 1'b1, 1'b0, MAX_CYCLES, 1'b0);
        cpu_finish = 1'b1;
        wait_idle("timeout", 4 * MAX_CYCLES);
        compare_result("timeout");

        // Finish rises exactly on the boundary cycle
        launch("boundary", 1'b0);
        cpu_finish = 1'b0;
        push_exp(1'b1, 1'b0, 1'b0, MAX_CYCLES - 1, 1'b1);
        steps(MAX_CYCLES - 1);
        check("boundary_pre_busy", 32'(busy), 32'd1);
        check("boundary_pre_cycles", 32'(cycles), 32'(MAX_CYCLES - 1));
        cpu_finish = 1'b1;
        wait_idle("boundary", 10);
        compare_result("boundary");

        // Abort 7 cycles into WAITHI
        launch("abort", 1'b0);
        cpu_finish = 1'b0;
        steps(1 + 7);
        push_exp(1'b0, 1'b0, 1'b1, 8, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        compare_result("abort");
        steps(3);
        check("abort_hold", 32'({aborted, cycles}), 32'({1'b1, CNT_W'(8)}));

        // Ignored go while busy, then reset mid-run (launch also checks aborted is cleared)
        launch("midrst", 1'b0);
        cpu_finish = 1'b0;
        steps(5);
        go = 1'b1;
        step();
        go = 1'b0;
        check("busy_go_ignored", 32'({busy, cpu_rst_b, cpu_start}), 32'b110);
        check("busy_go_cycles", 32'(cycles), 32'd6);
        step();
        rst_b = 1'b0;
        step();
        check("midrst_outs", 32'({cpu_rst_b, cpu_start, busy, done, timed_out, aborted}), 32'd0);
        check("midrst_cycles", 32'(cycles), 32'd0);
        rst_b = 1'b1;
        steps(3);
        check("midrst_idle", 32'({cpu_rst_b, busy}), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
